// File: rtl/exe_pkg.sv
// ---------------------------------------------------------------------------
// exe_pkg
// Shared definitions for the execute stage of the ARM-subset pipeline.
//   - 4-bit execute command encodings produced by the control unit
//   - bit positions of N, Z, C, V inside the 4-bit status register
//   - small helpers that classify a command (legal / arithmetic)
// ---------------------------------------------------------------------------
package exe_pkg;

    // Execute command encodings
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    // Status register bit positions, status = {N, Z, C, V}
    localparam int ST_N = 3;
    localparam int ST_Z = 2;
    localparam int ST_C = 1;
    localparam int ST_V = 0;

    // True for the nine commands the ALU implements. Anything else yields a
    // zero result and must never touch the flags.
    function automatic logic isLegalCmd(input logic [3:0] cmd);
        case (cmd)
            EXE_MOV, EXE_MVN, EXE_ADD, EXE_ADC, EXE_SUB,
            EXE_SBC, EXE_AND, EXE_ORR, EXE_EOR: isLegalCmd = 1'b1;
            default:                            isLegalCmd = 1'b0;
        endcase
    endfunction

    // True for the commands that produce meaningful C and V. Logical ops and
    // moves leave C and V untouched in the status register.
    function automatic logic isArithCmd(input logic [3:0] cmd);
        case (cmd)
            EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: isArithCmd = 1'b1;
            default:                            isArithCmd = 1'b0;
        endcase
    endfunction

endpackage : exe_pkg

// File: rtl/exe_alu.sv
// ---------------------------------------------------------------------------
// exe_alu
// Purely combinational ALU of the execute stage.
// Ports:
//   i_cmd    [3:0]       execute command (exe_pkg encodings)
//   i_a      [WIDTH-1:0] first operand (Rn)
//   i_b      [WIDTH-1:0] second operand (shifter output / immediate)
//   i_cIn                current registered carry flag (for ADC/SBC)
//   o_result [WIDTH-1:0] ALU result, 0 for an illegal command
//   o_n, o_z             negative / zero of o_result
//   o_c, o_v             carry / overflow; for non-arithmetic commands o_c
//                        echoes i_cIn and o_v is 0 (the caller preserves them)
//   o_legal              command is one of the implemented encodings
// ---------------------------------------------------------------------------
module exe_alu
    import exe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_cmd,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cIn,
    output logic [WIDTH-1:0] o_result,
    output logic             o_n,
    output logic             o_z,
    output logic             o_c,
    output logic             o_v,
    output logic             o_legal
);

    logic             w_isSub;
    logic [WIDTH-1:0] w_addB;
    logic             w_addCin;
    logic [WIDTH:0]   w_sum;

    // One shared WIDTH+1-bit adder serves all four arithmetic commands.
    // Subtraction is a + ~b + carry-in, so the adder's carry-out is already
    // the ARM "not borrow" carry: SUB forces carry-in 1, SBC uses the flag.
    always_comb begin
        w_isSub  = (i_cmd == EXE_SUB) || (i_cmd == EXE_SBC);
        w_addB   = w_isSub ? ~i_b : i_b;
        w_addCin = 1'b0;
        case (i_cmd)
            EXE_ADC, EXE_SBC: w_addCin = i_cIn;
            EXE_SUB:          w_addCin = 1'b1;
            default:          w_addCin = 1'b0;
        endcase
        w_sum = {1'b0, i_a} + {1'b0, w_addB} + {{WIDTH{1'b0}}, w_addCin};
    end

    // Result selection and flag generation. Overflow compares the sign of a
    // against the sign of the (possibly inverted) b actually fed to the adder.
    always_comb begin
        o_result = '0;
        o_c      = i_cIn;
        o_v      = 1'b0;
        o_legal  = isLegalCmd(i_cmd);
        case (i_cmd)
            EXE_MOV: o_result = i_b;
            EXE_MVN: o_result = ~i_b;
            EXE_AND: o_result = i_a & i_b;
            EXE_ORR: o_result = i_a | i_b;
            EXE_EOR: o_result = i_a ^ i_b;
            EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: begin
                o_result = w_sum[WIDTH-1:0];
                o_c      = w_sum[WIDTH];
                o_v      = (i_a[WIDTH-1] == w_addB[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            default: o_result = '0;
        endcase
        o_n = o_result[WIDTH-1];
        o_z = (o_result == '0);
    end

endmodule : exe_alu

// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage
// Execute stage of the ARM-subset pipeline. Runs the ALU on the ID/EX bundle,
// owns the {N,Z,C,V} status register, computes the branch redirect and
// registers results into the EX/MEM pipeline register.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   freeze                         memory stall: EX/MEM and status hold
//   in_valid                       ID/EX slot holds a real instruction
//   exe_cmd [3:0]                  execute command
//   mem_r_en_in, mem_w_en_in,
//   wb_en_in, b_in, s_in           control bits from the control unit
//   val_rn, val2, val_rm [WIDTH]   operand 1, operand 2, store data
//   dest_in [3:0]                  destination register index
//   pc_in [WIDTH]                  PC+4 of this instruction
//   imm24 [23:0]                   signed branch word offset
//   status_out [3:0]               registered {N,Z,C,V}
//   branch_taken, branch_addr      combinational fetch redirect
//   alu_result_out, val_rm_out,
//   dest_out, wb_en_out,
//   mem_r_en_out, mem_w_en_out,
//   out_valid                      EX/MEM register outputs
// ---------------------------------------------------------------------------
module exe_stage
    import exe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             in_valid,
    input  logic [3:0]       exe_cmd,
    input  logic             mem_r_en_in,
    input  logic             mem_w_en_in,
    input  logic             wb_en_in,
    input  logic             b_in,
    input  logic             s_in,
    input  logic [WIDTH-1:0] val_rn,
    input  logic [WIDTH-1:0] val2,
    input  logic [WIDTH-1:0] val_rm,
    input  logic [3:0]       dest_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [23:0]      imm24,
    output logic [3:0]       status_out,
    output logic             branch_taken,
    output logic [WIDTH-1:0] branch_addr,
    output logic [WIDTH-1:0] alu_result_out,
    output logic [WIDTH-1:0] val_rm_out,
    output logic [3:0]       dest_out,
    output logic             wb_en_out,
    output logic             mem_r_en_out,
    output logic             mem_w_en_out,
    output logic             out_valid
);

    logic [3:0]       r_status;
    logic [WIDTH-1:0] r_aluResult;
    logic [WIDTH-1:0] r_valRm;
    logic [3:0]       r_dest;
    logic             r_wbEn;
    logic             r_memREn;
    logic             r_memWEn;
    logic             r_valid;

    logic [WIDTH-1:0] w_aluResult;
    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_v;
    logic             w_legal;
    logic             w_statusWe;
    logic [WIDTH-1:0] w_branchOffset;

    exe_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_cmd    (exe_cmd),
        .i_a      (val_rn),
        .i_b      (val2),
        .i_cIn    (r_status[ST_C]),
        .o_result (w_aluResult),
        .o_n      (w_n),
        .o_z      (w_z),
        .o_c      (w_c),
        .o_v      (w_v),
        .o_legal  (w_legal)
    );

    // Flags are written only by real, legal, S-suffixed data-processing
    // instructions. The control unit also raises S on LDR, so any memory
    // access is excluded here; a stalled pipeline must not commit either.
    assign w_statusWe = in_valid & s_in & ~mem_r_en_in & ~mem_w_en_in
                      & ~freeze & w_legal;

    // Status register. N and Z follow every write; C and V only change for
    // arithmetic commands so logical ops and moves keep the previous carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= '0;
        end else if (w_statusWe) begin
            r_status[ST_N] <= w_n;
            r_status[ST_Z] <= w_z;
            if (isArithCmd(exe_cmd)) begin
                r_status[ST_C] <= w_c;
                r_status[ST_V] <= w_v;
            end
        end
    end

    // EX/MEM pipeline register. Data fields load unconditionally when not
    // frozen; control bits are gated by in_valid so a bubble can never write
    // the register file or memory downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aluResult <= '0;
            r_valRm     <= '0;
            r_dest      <= '0;
            r_wbEn      <= 1'b0;
            r_memREn    <= 1'b0;
            r_memWEn    <= 1'b0;
            r_valid     <= 1'b0;
        end else if (!freeze) begin
            r_aluResult <= w_aluResult;
            r_valRm     <= val_rm;
            r_dest      <= dest_in;
            r_wbEn      <= wb_en_in & in_valid;
            r_memREn    <= mem_r_en_in & in_valid;
            r_memWEn    <= mem_w_en_in & in_valid;
            r_valid     <= in_valid;
        end
    end

    // Branch target: the 24-bit word offset is sign-extended and scaled to
    // bytes, then added to PC+4. The sum wraps naturally at WIDTH bits.
    assign w_branchOffset = {{(WIDTH-26){imm24[23]}}, imm24, 2'b00};
    assign branch_addr    = pc_in + w_branchOffset;
    assign branch_taken   = in_valid & b_in;

    assign status_out     = r_status;
    assign alu_result_out = r_aluResult;
    assign val_rm_out     = r_valRm;
    assign dest_out       = r_dest;
    assign wb_en_out      = r_wbEn;
    assign mem_r_en_out   = r_memREn;
    assign mem_w_en_out   = r_memWEn;
    assign out_valid      = r_valid;

endmodule : exe_stage

// File: tb/tb_exe_stage.sv
// ---------------------------------------------------------------------------
// tb_exe_stage
// Directed, table-driven bench for exe_stage. Each record holds the inputs of
// one instruction and the hand-computed EX/MEM, status and branch outputs.
// Records are applied in order, so status expectations chain from row to row.
// Hand-written sequences cover reset, freeze and reset-over-freeze.
// ---------------------------------------------------------------------------
module tb_exe_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        in_valid;
    logic [3:0]  exe_cmd;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic        wb_en_in;
    logic        b_in;
    logic        s_in;
    logic [31:0] val_rn;
    logic [31:0] val2;
    logic [31:0] val_rm;
    logic [3:0]  dest_in;
    logic [31:0] pc_in;
    logic [23:0] imm24;
    logic [3:0]  status_out;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] alu_result_out;
    logic [31:0] val_rm_out;
    logic [3:0]  dest_out;
    logic        wb_en_out;
    logic        mem_r_en_out;
    logic        mem_w_en_out;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    // ctlIn = {s, wb, mem_r, mem_w, b, valid}
    // expCtl = {wb_en_out, mem_r_en_out, mem_w_en_out, out_valid}
    typedef struct {
        logic [3:0]  cmd;
        logic [5:0]  ctlIn;
        logic [31:0] rn;
        logic [31:0] v2;
        logic [31:0] rm;
        logic [3:0]  dest;
        logic [31:0] pc;
        logic [23:0] imm;
        logic [31:0] expRes;
        logic [3:0]  expStatus;
        logic [3:0]  expCtl;
        logic        expBt;
        logic [31:0] expBa;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    exe_stage #(
        .WIDTH (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .in_valid       (in_valid),
        .exe_cmd        (exe_cmd),
        .mem_r_en_in    (mem_r_en_in),
        .mem_w_en_in    (mem_w_en_in),
        .wb_en_in       (wb_en_in),
        .b_in           (b_in),
        .s_in           (s_in),
        .val_rn         (val_rn),
        .val2           (val2),
        .val_rm         (val_rm),
        .dest_in        (dest_in),
        .pc_in          (pc_in),
        .imm24          (imm24),
        .status_out     (status_out),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .alu_result_out (alu_result_out),
        .val_rm_out     (val_rm_out),
        .dest_out       (dest_out),
        .wb_en_out      (wb_en_out),
        .mem_r_en_out   (mem_r_en_out),
        .mem_w_en_out   (mem_w_en_out),
        .out_valid      (out_valid)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Drive one table record; inputs change on the falling edge
    task automatic applyStimulus(input vec_t v);
        exe_cmd     = v.cmd;
        s_in        = v.ctlIn[5];
        wb_en_in    = v.ctlIn[4];
        mem_r_en_in = v.ctlIn[3];
        mem_w_en_in = v.ctlIn[2];
        b_in        = v.ctlIn[1];
        in_valid    = v.ctlIn[0];
        val_rn      = v.rn;
        val2        = v.v2;
        val_rm      = v.rm;
        dest_in     = v.dest;
        pc_in       = v.pc;
        imm24       = v.imm;
    endtask

    // Scramble every data/control input while reset or freeze is asserted
    task automatic randomInputs();
        in_valid    = 1'($urandom);
        exe_cmd     = 4'($urandom);
        mem_r_en_in = 1'($urandom);
        mem_w_en_in = 1'($urandom);
        wb_en_in    = 1'($urandom);
        b_in        = 1'($urandom);
        s_in        = 1'($urandom);
        val_rn      = $urandom;
        val2        = $urandom;
        val_rm      = $urandom;
        dest_in     = 4'($urandom);
        pc_in       = $urandom;
        imm24       = 24'($urandom);
    endtask

    // All registered outputs at their reset value
    task automatic checkRegsZero(input string tag);
        checkOutput({tag, " status"}, {28'd0, status_out}, 32'h0);
        checkOutput({tag, " res"}, alu_result_out, 32'h0);
        checkOutput({tag, " rm"}, val_rm_out, 32'h0);
        checkOutput({tag, " dest"}, {28'd0, dest_out}, 32'h0);
        checkOutput({tag, " ctl"},
                    {28'd0, wb_en_out, mem_r_en_out, mem_w_en_out, out_valid},
                    32'h0);
    endtask

    initial begin
        // -------------------------------------------------------------- table
        vecs[0]  = '{4'h2, 6'b110001, 32'h7FFFFFFF, 32'h1, 32'hA1, 4'd1, 32'h0, 24'h0,
                     32'h80000000, 4'b1001, 4'b1001, 1'b0, 32'h0};      // ADDS overflow
        vecs[1]  = '{4'h4, 6'b100001, 32'h5, 32'h5, 32'hA2, 4'd2, 32'h0, 24'h0,
                     32'h0, 4'b0110, 4'b0001, 1'b0, 32'h0};             // CMP 5,5
        vecs[2]  = '{4'h5, 6'b110001, 32'hA, 32'h3, 32'hA3, 4'd3, 32'h0, 24'h0,
                     32'h7, 4'b0010, 4'b1001, 1'b0, 32'h0};             // SBC C=1
        vecs[3]  = '{4'h4, 6'b110001, 32'h3, 32'h5, 32'hA4, 4'd4, 32'h0, 24'h0,
                     32'hFFFFFFFE, 4'b1000, 4'b1001, 1'b0, 32'h0};      // SUBS borrow
        vecs[4]  = '{4'h5, 6'b110001, 32'hA, 32'h3, 32'hA5, 4'd5, 32'h0, 24'h0,
                     32'h6, 4'b0010, 4'b1001, 1'b0, 32'h0};             // SBC C=0
        vecs[5]  = '{4'h4, 6'b100001, 32'h5, 32'h5, 32'hA6, 4'd6, 32'h0, 24'h0,
                     32'h0, 4'b0110, 4'b0001, 1'b0, 32'h0};             // CMP -> 0110
        vecs[6]  = '{4'h2, 6'b111001, 32'h1000, 32'h24, 32'hA7, 4'd7, 32'h0, 24'h0,
                     32'h1024, 4'b0110, 4'b1101, 1'b0, 32'h0};          // LDR, S ignored
        vecs[7]  = '{4'h2, 6'b110001, 32'h1, 32'h1, 32'hA8, 4'd8, 32'h0, 24'h0,
                     32'h2, 4'b0000, 4'b1001, 1'b0, 32'h0};             // ADDS clears C
        vecs[8]  = '{4'h3, 6'b010001, 32'h1, 32'h2, 32'hA9, 4'd9, 32'h0, 24'h0,
                     32'h3, 4'b0000, 4'b1001, 1'b0, 32'h0};             // ADC new C=0
        vecs[9]  = '{4'h9, 6'b110001, 32'h0, 32'h0, 32'hAA, 4'd10, 32'h0, 24'h0,
                     32'hFFFFFFFF, 4'b1000, 4'b1001, 1'b0, 32'h0};      // MVNS
        vecs[10] = '{4'h6, 6'b100001, 32'hF0, 32'h0F, 32'hAB, 4'd11, 32'h0, 24'h0,
                     32'h0, 4'b0100, 4'b0001, 1'b0, 32'h0};             // TST -> Z
        vecs[11] = '{4'h7, 6'b110001, 32'hF00, 32'hF0, 32'hAC, 4'd12, 32'h0, 24'h0,
                     32'hFF0, 4'b0000, 4'b1001, 1'b0, 32'h0};           // ORRS
        vecs[12] = '{4'h8, 6'b110001, 32'hFF, 32'h0F, 32'hAD, 4'd13, 32'h0, 24'h0,
                     32'hF0, 4'b0000, 4'b1001, 1'b0, 32'h0};            // EORS
        vecs[13] = '{4'h1, 6'b010001, 32'hFFFF, 32'h1234, 32'hAE, 4'd14, 32'h0, 24'h0,
                     32'h1234, 4'b0000, 4'b1001, 1'b0, 32'h0};          // MOV
        vecs[14] = '{4'h0, 6'b110001, 32'h5, 32'h5, 32'hAF, 4'd15, 32'h0, 24'h0,
                     32'h0, 4'b0000, 4'b1001, 1'b0, 32'h0};             // illegal cmd
        vecs[15] = '{4'h2, 6'b110010, 32'hFFFFFFFF, 32'h1, 32'hB0, 4'd1, 32'h40, 24'h1,
                     32'h0, 4'b0000, 4'b0000, 1'b0, 32'h44};            // bubble
        vecs[16] = '{4'h0, 6'b000011, 32'h0, 32'h0, 32'hB1, 4'd0, 32'h100, 24'hFFFFFE,
                     32'h0, 4'b0000, 4'b0001, 1'b1, 32'hF8};            // B backward
        vecs[17] = '{4'h0, 6'b000011, 32'h0, 32'h0, 32'hB2, 4'd0, 32'hFFFFFFFC, 24'h2,
                     32'h0, 4'b0000, 4'b0001, 1'b1, 32'h4};             // B wraps
        vecs[18] = '{4'h4, 6'b110001, 32'h80000000, 32'h1, 32'hB3, 4'd2, 32'h0, 24'h0,
                     32'h7FFFFFFF, 4'b0011, 4'b1001, 1'b0, 32'h0};      // SUBS overflow
        vecs[19] = '{4'h2, 6'b100101, 32'h200, 32'h8, 32'hDEAD, 4'd3, 32'h0, 24'h0,
                     32'h208, 4'b0011, 4'b0011, 1'b0, 32'h0};           // STR, S ignored

        // ------------------------------------------------------------- reset
        rst    = 1'b1;
        freeze = 1'b0;
        randomInputs();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            randomInputs();
            @(posedge clk);
            #1;
            checkRegsZero($sformatf("reset%0d", c));
        end
        @(negedge clk);
        rst = 1'b0;

        // ------------------------------------------------------ table vectors
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d branch_taken", i), {31'd0, branch_taken},
                        {31'd0, vecs[i].expBt});
            checkOutput($sformatf("v%0d branch_addr", i), branch_addr, vecs[i].expBa);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d res", i), alu_result_out, vecs[i].expRes);
            checkOutput($sformatf("v%0d status", i), {28'd0, status_out},
                        {28'd0, vecs[i].expStatus});
            checkOutput($sformatf("v%0d ctl", i),
                        {28'd0, wb_en_out, mem_r_en_out, mem_w_en_out, out_valid},
                        {28'd0, vecs[i].expCtl});
            checkOutput($sformatf("v%0d dest", i), {28'd0, dest_out},
                        {28'd0, vecs[i].dest});
            checkOutput($sformatf("v%0d rm", i), val_rm_out, vecs[i].rm);
            @(negedge clk);
        end

        // ---------------------------------- freeze during ADDS for 3 cycles
        exe_cmd = 4'h2; s_in = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b0;
        mem_w_en_in = 1'b0; b_in = 1'b0; in_valid = 1'b1;
        val_rn = 32'h1; val2 = 32'h1; val_rm = 32'hC0DE; dest_in = 4'd9;
        pc_in = 32'h0; imm24 = 24'h0;
        freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("frz%0d res", c), alu_result_out, 32'h208);
            checkOutput($sformatf("frz%0d status", c), {28'd0, status_out}, 32'h3);
            checkOutput($sformatf("frz%0d ctl", c),
                        {28'd0, wb_en_out, mem_r_en_out, mem_w_en_out, out_valid},
                        32'h3);
            checkOutput($sformatf("frz%0d rm", c), val_rm_out, 32'hDEAD);
        end
        @(negedge clk);
        freeze = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("unfrz res", alu_result_out, 32'h2);
        checkOutput("unfrz status", {28'd0, status_out}, 32'h0);
        checkOutput("unfrz ctl",
                    {28'd0, wb_en_out, mem_r_en_out, mem_w_en_out, out_valid}, 32'h9);
        checkOutput("unfrz dest", {28'd0, dest_out}, 32'h9);

        // ------------------------------------- reset wins over freeze
        @(negedge clk);
        exe_cmd = 4'h9; val2 = 32'h0;      // MVNS would set N if it committed
        freeze = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("pre-rst res held", alu_result_out, 32'h2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkRegsZero("rst+freeze");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_exe_stage
